gpio_port_array: RTL and testbench



---
 rtl/gpio_port_array.sv | 143 ++++++++++++++
 tb/tb_gpio_port_array.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_array.sv
// Bank of NUM_PORTS x WIDTH bidirectional GPIO ports with per-bit direction,
// synchronised inputs, rising-edge interrupt status and a 1-cycle read bus.
module gpio_port_array #(
  parameter int NUM_PORTS   = 3,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  inout  wire  [NUM_PORTS*WIDTH-1:0] gpio_io,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       wr_i,
  input  logic                       rd_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       rvalid_o,
  output logic                       irq_o
);

  localparam int PORT_W     = ADDR_W - 3;
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W      = $clog2(ARM_CYCLES + 1);

  localparam logic [2:0] REG_OUT = 3'd0;
  localparam logic [2:0] REG_DIR = 3'd1;
  localparam logic [2:0] REG_IN  = 3'd2;
  localparam logic [2:0] REG_IE  = 3'd3;
  localparam logic [2:0] REG_IS  = 3'd4;

  logic [PORT_W-1:0]          port_idx;
  logic [2:0]                 reg_idx;
  logic [NUM_PORTS-1:0]       port_sel;
  logic [NUM_PORTS-1:0]       port_pend;
  logic [NUM_PORTS*WIDTH-1:0] port_rdata_flat;
  logic [WIDTH-1:0]           rdata_next;
  logic [CNT_W-1:0]           arm_cnt_reg;
  logic                       armed;

  assign port_idx = addr_i[ADDR_W-1:3];
  assign reg_idx  = addr_i[2:0];

  // Pins already high at reset release must not look like fresh edges while
  // the synchroniser and edge history fill up.
  assign armed = (arm_cnt_reg == CNT_W'(ARM_CYCLES));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arm_cnt_reg <= '0;
    end else if (!armed) begin
      arm_cnt_reg <= arm_cnt_reg + CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [WIDTH-1:0] out_reg;
      logic [WIDTH-1:0] dir_reg;
      logic [WIDTH-1:0] ie_reg;
      logic [WIDTH-1:0] is_reg;
      logic [WIDTH-1:0] is_next;
      logic [WIDTH-1:0] prev_reg;
      logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
      logic [WIDTH-1:0] sync_out;
      logic [WIDTH-1:0] rise;
      logic [WIDTH-1:0] clr;
      logic [WIDTH-1:0] port_rdata;
      logic             wr_port;

      assign port_sel[gi] = (port_idx == PORT_W'(gi));
      assign wr_port      = wr_i & port_sel[gi];
      assign sync_out     = sync_reg[SYNC_STAGES-1];

      // Output-mode bits never raise status, using this cycle's DIR value.
      assign rise    = sync_out & ~prev_reg & ~dir_reg & {WIDTH{armed}};
      assign clr     = (wr_port && reg_idx == REG_IS) ? data_i : '0;
      assign is_next = (is_reg & ~clr) | rise;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          out_reg  <= '0;
          dir_reg  <= '0;
          ie_reg   <= '0;
          is_reg   <= '0;
          prev_reg <= '0;
          for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_reg[s] <= '0;
          end
        end else begin
          if (wr_port && reg_idx == REG_OUT) out_reg <= data_i;
          if (wr_port && reg_idx == REG_DIR) dir_reg <= data_i;
          if (wr_port && reg_idx == REG_IE)  ie_reg  <= data_i;
          is_reg      <= is_next;
          prev_reg    <= sync_out;
          sync_reg[0] <= gpio_io[gi*WIDTH +: WIDTH];
          for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_reg[s] <= sync_reg[s-1];
          end
        end
      end

      always_comb begin
        port_rdata = '0;
        case (reg_idx)
          REG_OUT: port_rdata = out_reg;
          REG_DIR: port_rdata = dir_reg;
          REG_IN:  port_rdata = sync_out;
          REG_IE:  port_rdata = ie_reg;
          REG_IS:  port_rdata = is_reg;
          default: port_rdata = '0;
        endcase
      end

      assign port_rdata_flat[gi*WIDTH +: WIDTH] = port_rdata;
      assign port_pend[gi] = |(is_reg & ie_reg);

      for (genvar bi = 0; bi < WIDTH; bi++) begin : g_pin
        assign gpio_io[gi*WIDTH + bi] = dir_reg[bi] ? out_reg[bi] : 1'bz;
      end
    end
  endgenerate

  // Port indices past NUM_PORTS match no port_sel bit and read as zero.
  always_comb begin
    rdata_next = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_sel[p]) rdata_next = port_rdata_flat[p*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o   <= '0;
      rvalid_o <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      rvalid_o <= rd_i;
      if (rd_i) data_o <= rdata_next;
      irq_o <= |port_pend;
    end
  end

endmodule

// File: tb/tb_gpio_port_array.sv
// Directed bench for gpio_port_array: reset, direction, edge IRQ, set/clear
// priority, read/write collisions, unmapped accesses and async reset.
module tb_gpio_port_array;

  localparam int NP = 3;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int AW = 6;

  localparam logic [2:0] R_OUT = 3'd0;
  localparam logic [2:0] R_DIR = 3'd1;
  localparam logic [2:0] R_IN  = 3'd2;
  localparam logic [2:0] R_IE  = 3'd3;
  localparam logic [2:0] R_IS  = 3'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          irq;
  logic [NP*W-1:0] ext_en = '1;
  logic [NP*W-1:0] ext_val = '1;
  wire  [NP*W-1:0] gpio;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NP*W; gi++) begin : g_drv
      assign gpio[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
    end
  endgenerate

  gpio_port_array #(
    .NUM_PORTS(NP), .WIDTH(W), .SYNC_STAGES(SS), .ADDR_W(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .gpio_io(gpio), .addr_i(addr),
    .data_i(wdata), .wr_i(wr), .rd_i(rd), .data_o(rdata),
    .rvalid_o(rvalid), .irq_o(irq)
  );

  // Bus helpers are entered 1ns after a rising edge and return likewise.
  task automatic bus_write(input logic [2:0] port, input logic [2:0] r, input logic [7:0] d);
    addr = {port, r};
    wdata = d;
    wr = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] port, input logic [2:0] r,
                          output logic [7:0] d, output logic v);
    addr = {port, r};
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    d = rdata;
    v = rvalid;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic v;
    rst_n = 1'b0;
    ext_en = '1;
    ext_val = '1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (gpio !== 24'hFFFFFF) $display("FAIL reset_pins: got %h expected %h", gpio, 24'hFFFFFF); else passed++;
    total++; if (rdata !== 8'h00) $display("FAIL reset_data: got %h expected %h", rdata, 8'h00); else passed++;
    total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b expected 0", rvalid); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else passed++;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      bus_read(3'(p), R_IS, d, v);
      total++;
      if ({v, d} !== 9'h100) $display("FAIL reset_is_p%0d: got v=%b d=%h expected v=1 d=00", p, v, d);
      else passed++;
    end
    bus_read(3'd1, R_DIR, d, v);
    total++; if (d !== 8'h00) $display("FAIL reset_dir: got %h expected %h", d, 8'h00); else passed++;
    ext_val = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_direction;
    logic [7:0] d;
    logic v;
    bus_write(3'd1, R_OUT, 8'hA5);
    ext_val[15:8] = 8'h35;
    bus_write(3'd1, R_DIR, 8'h0F);
    ext_en[15:8] = 8'hF0;
    total++; if (gpio[15:8] !== 8'h35) $display("FAIL dir_pins: got %h expected %h", gpio[15:8], 8'h35); else passed++;
    repeat (SS + 1) @(posedge clk);
    #1;
    bus_read(3'd1, R_IN, d, v);
    total++; if (d !== 8'h35) $display("FAIL dir_in: got %h expected %h", d, 8'h35); else passed++;
    total++; if (v !== 1'b1) $display("FAIL dir_rvalid: got %b expected 1", v); else passed++;
    @(posedge clk);
    #1;
    total++; if (rvalid !== 1'b0) $display("FAIL dir_rvalid_drop: got %b expected 0", rvalid); else passed++;
    bus_read(3'd1, R_OUT, d, v);
    total++; if (d !== 8'hA5) $display("FAIL dir_out_rb: got %h expected %h", d, 8'hA5); else passed++;
    // Bits 0 and 2 rose only after DIR made them outputs, so only 4 and 5 latch.
    bus_read(3'd1, R_IS, d, v);
    total++; if (d !== 8'h30) $display("FAIL dir_is: got %h expected %h", d, 8'h30); else passed++;
  endtask

  task automatic test_edge_irq;
    logic [7:0] d;
    logic v;
    int n;
    bus_write(3'd2, R_IE, 8'h01);
    ext_val[16] = 1'b1;
    n = 0;
    while (irq !== 1'b1 && n < SS + 2) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (irq !== 1'b1) $display("FAIL edge_irq_rise: got %b expected 1 within %0d cycles", irq, SS + 2); else passed++;
    bus_read(3'd2, R_IS, d, v);
    total++; if (d !== 8'h01) $display("FAIL edge_is0: got %h expected %h", d, 8'h01); else passed++;
    ext_val[17] = 1'b1;
    repeat (SS + 2) @(posedge clk);
    #1;
    bus_read(3'd2, R_IS, d, v);
    total++; if (d !== 8'h03) $display("FAIL edge_is1: got %h expected %h", d, 8'h03); else passed++;
    bus_write(3'd2, R_IS, 8'h01);
    total++; if (irq !== 1'b1) $display("FAIL edge_irq_hold: got %b expected 1", irq); else passed++;
    @(posedge clk);
    #1;
    total++; if (irq !== 1'b0) $display("FAIL edge_irq_drop: got %b expected 0", irq); else passed++;
    bus_read(3'd2, R_IS, d, v);
    total++; if (d !== 8'h02) $display("FAIL edge_is_clr: got %h expected %h", d, 8'h02); else passed++;
  endtask

  task automatic test_set_clear;
    logic [7:0] d;
    logic v;
    ext_val[16] = 1'b0;
    repeat (SS + 2) @(posedge clk);
    #1;
    bus_read(3'd2, R_IS, d, v);
    total++; if (d !== 8'h02) $display("FAIL fall_no_set: got %h expected %h", d, 8'h02); else passed++;
    ext_val[16] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    // The clear below lands on the same edge that latches the bit0 rise.
    bus_write(3'd2, R_IS, 8'h01);
    bus_read(3'd2, R_IS, d, v);
    total++; if (d !== 8'h03) $display("FAIL set_wins: got %h expected %h", d, 8'h03); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    logic v;
    bus_write(3'd0, R_OUT, 8'h11);
    addr = {3'd0, R_OUT};
    wdata = 8'h3C;
    wr = 1'b1;
    rd = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
    total++; if ({rvalid, rdata} !== 9'h111) $display("FAIL rw_prewrite: got v=%b d=%h expected v=1 d=11", rvalid, rdata); else passed++;
    @(posedge clk);
    #1;
    rd = 1'b0;
    total++; if ({rvalid, rdata} !== 9'h13C) $display("FAIL b2b_second: got v=%b d=%h expected v=1 d=3c", rvalid, rdata); else passed++;
    @(posedge clk);
    #1;
    total++; if ({rvalid, rdata} !== 9'h03C) $display("FAIL b2b_hold: got v=%b d=%h expected v=0 d=3c", rvalid, rdata); else passed++;
  endtask

  task automatic test_unmapped;
    logic [7:0] d;
    logic v;
    bus_write(3'd3, R_OUT, 8'hFF);
    bus_write(3'd0, 3'd6, 8'hFF);
    bus_read(3'd0, R_OUT, d, v);
    total++; if (d !== 8'h3C) $display("FAIL unm_out_kept: got %h expected %h", d, 8'h3C); else passed++;
    bus_read(3'd3, R_OUT, d, v);
    total++; if ({v, d} !== 9'h100) $display("FAIL unm_port3: got v=%b d=%h expected v=1 d=00", v, d); else passed++;
    bus_read(3'd0, 3'd6, d, v);
    total++; if ({v, d} !== 9'h100) $display("FAIL unm_off6: got v=%b d=%h expected v=1 d=00", v, d); else passed++;
    bus_read(3'd0, R_DIR, d, v);
    total++; if (d !== 8'h00) $display("FAIL unm_dir_kept: got %h expected %h", d, 8'h00); else passed++;
    bus_read(3'd0, R_IE, d, v);
    total++; if (d !== 8'h00) $display("FAIL unm_ie_kept: got %h expected %h", d, 8'h00); else passed++;
  endtask

  task automatic test_reset_midop;
    logic [7:0] d;
    logic v;
    bus_write(3'd0, R_OUT, 8'h55);
    bus_write(3'd0, R_DIR, 8'hFF);
    ext_en[7:0] = 8'h00;
    total++; if (gpio[7:0] !== 8'h55) $display("FAIL mid_drive: got %h expected %h", gpio[7:0], 8'h55); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL mid_irq_pre: got %b expected 1", irq); else passed++;
    addr = {3'd0, R_OUT};
    rd = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    rd = 1'b0;
    ext_en[7:0] = 8'hFF;
    ext_val[7:0] = 8'hAA;
    #1;
    total++; if (gpio[7:0] !== 8'hAA) $display("FAIL mid_pins_rel: got %h expected %h", gpio[7:0], 8'hAA); else passed++;
    total++; if (rvalid !== 1'b0) $display("FAIL mid_rvalid: got %b expected 0", rvalid); else passed++;
    total++; if (rdata !== 8'h00) $display("FAIL mid_data: got %h expected %h", rdata, 8'h00); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL mid_irq: got %b expected 0", irq); else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus_read(3'd0, R_OUT, d, v);
    total++; if (d !== 8'h00) $display("FAIL mid_out0: got %h expected %h", d, 8'h00); else passed++;
    bus_read(3'd0, R_DIR, d, v);
    total++; if (d !== 8'h00) $display("FAIL mid_dir0: got %h expected %h", d, 8'h00); else passed++;
    bus_read(3'd0, R_IS, d, v);
    total++; if (d !== 8'h00) $display("FAIL mid_is0: got %h expected %h", d, 8'h00); else passed++;
    bus_read(3'd2, R_IS, d, v);
    total++; if (d !== 8'h00) $display("FAIL mid_is2: got %h expected %h", d, 8'h00); else passed++;
    ext_val[0] = 1'b1;
    repeat (SS + 2) @(posedge clk);
    #1;
    bus_read(3'd0, R_IS, d, v);
    total++; if (d !== 8'h01) $display("FAIL mid_rearmed: got %h expected %h", d, 8'h01); else passed++;
  endtask

  initial begin
    test_reset();
    test_direction();
    test_edge_irq();
    test_set_clear();
    test_back_to_back();
    test_unmapped();
    test_reset_midop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
